// File: rtl/fwd_pkg.sv
// ============================================================================
// Module   : fwd_pkg
// Brief    : Shared constants, entry type and sizing helper for the forwarding scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fwd_pkg;

    localparam int FWD_SEL_REGFILE = 0;
    localparam int FWD_REG_ADDR_W  = 5;
    localparam int FWD_LAT_W       = 2;

    typedef struct packed {
        logic                      valid;
        logic [FWD_REG_ADDR_W-1:0] rd;
        logic [FWD_LAT_W-1:0]      cnt;
    } fwd_entry_t;

    function automatic int fwd_clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r++;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fwd_match.sv
// ============================================================================
// Module   : fwd_match
// Brief    : Per-source lookup: youngest matching in-flight writer selects or stalls.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_match
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 2,
    parameter int LAT_W      = 2,
    parameter int SEL_W      = 2
) (
    input  logic [REG_ADDR_W-1:0]       src_i,
    input  logic [DEPTH-1:0]            valid_i,
    input  logic [DEPTH*REG_ADDR_W-1:0] rd_i,
    input  logic [DEPTH*LAT_W-1:0]      cnt_i,
    output logic [SEL_W-1:0]            sel_o,
    output logic                        stall_req_o
);

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        sel_o       = SEL_W'(FWD_SEL_REGFILE);
        stall_req_o = 1'b0;
        if (src_i != '0) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (valid_i[k] && (rd_i[k*REG_ADDR_W +: REG_ADDR_W] == src_i)) begin
                    if (cnt_i[k*LAT_W +: LAT_W] == '0) begin
                        sel_o       = SEL_W'(k + 1);
                        stall_req_o = 1'b0;
                    end else begin
                        sel_o       = SEL_W'(FWD_SEL_REGFILE);
                        stall_req_o = 1'b1;
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fwd_scoreboard.sv
// ============================================================================
// Module   : fwd_scoreboard
// Brief    : Shift-register scoreboard of in-flight writes driving EX operand
//            forwarding selects and a load-use / multi-cycle stall.
//            Optional stall/forward counters under FWD_STALL_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter  int REG_ADDR_W = FWD_REG_ADDR_W,
    parameter  int NUM_SRC    = 2,
    parameter  int DEPTH      = 2,
    parameter  int LAT_W      = FWD_LAT_W,
    localparam int SEL_W      = fwd_clog2(DEPTH + 1)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          ex_valid_i,
    input  logic                          ex_reg_write_i,
    input  logic [REG_ADDR_W-1:0]         ex_rd_i,
    input  logic [LAT_W-1:0]              ex_lat_i,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] ex_src_i,
    input  logic                          flush_i,
    output logic [NUM_SRC*SEL_W-1:0]      fwd_sel_o,
    output logic                          stall_o
`ifdef FWD_STALL_STATS_EN
    ,
    output logic [31:0]                   stall_cnt_o,
    output logic [31:0]                   fwd_cnt_o
`endif
);

    localparam logic [31:0] MAX_LAT = 32'(DEPTH - 1);

    // Stage k+1 of the scoreboard lives at index k.
    logic [DEPTH-1:0]            valid_q, valid_d;
    logic [DEPTH*REG_ADDR_W-1:0] rd_q, rd_d;
    logic [DEPTH*LAT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_SRC-1:0]          stall_req;
    logic [LAT_W-1:0]            lat_clamped;
    logic                        commit;

    assign stall_o = ex_valid_i & ~flush_i & (|stall_req);
    assign commit  = ex_valid_i & ex_reg_write_i & (ex_rd_i != '0) & ~stall_o & ~flush_i;

    // Clamping bounds every stall to DEPTH-1 cycles: the producer is ready by the last stage.
    always_comb begin
        lat_clamped = ex_lat_i;
        if (32'(ex_lat_i) > MAX_LAT) begin
            lat_clamped = LAT_W'(MAX_LAT);
        end
    end

    always_comb begin
        valid_d    = '0;
        rd_d       = '0;
        cnt_d      = '0;
        valid_d[0] = commit;
        if (commit) begin
            rd_d[REG_ADDR_W-1:0] = ex_rd_i;
            cnt_d[LAT_W-1:0]     = lat_clamped;
        end
        for (int k = 1; k < DEPTH; k++) begin
            valid_d[k]                          = valid_q[k-1];
            rd_d[k*REG_ADDR_W +: REG_ADDR_W]    = rd_q[(k-1)*REG_ADDR_W +: REG_ADDR_W];
            cnt_d[k*LAT_W +: LAT_W]             = (cnt_q[(k-1)*LAT_W +: LAT_W] == '0) ?
                                                  '0 : cnt_q[(k-1)*LAT_W +: LAT_W] - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

    generate
        for (genvar j = 0; j < NUM_SRC; j++) begin : g_src
            fwd_match #(
                .REG_ADDR_W (REG_ADDR_W),
                .DEPTH      (DEPTH),
                .LAT_W      (LAT_W),
                .SEL_W      (SEL_W)
            ) u_match (
                .src_i       (ex_src_i[j*REG_ADDR_W +: REG_ADDR_W]),
                .valid_i     (valid_q),
                .rd_i        (rd_q),
                .cnt_i       (cnt_q),
                .sel_o       (fwd_sel_o[j*SEL_W +: SEL_W]),
                .stall_req_o (stall_req[j])
            );
        end
    endgenerate

`ifdef FWD_STALL_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] fwd_cnt_q, fwd_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, stall_o};
        fwd_cnt_d   = fwd_cnt_q + {31'd0, (|fwd_sel_o) & ~stall_o};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign fwd_cnt_o   = fwd_cnt_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

`default_nettype wire
